// File: rtl/watch_set_controller.sv
// Front-panel sequencer: conditions three raw buttons and runs the normal/setting FSM for the watch datapath.
// Optional WATCH_SET_AUTOREPEAT_EN adds hold-to-repeat on btn_inc, paced by tick_2hz.
module watch_set_controller #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_SEC     = 10,
    parameter int REPEAT_DELAY    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       tick_2hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic       mode,
    output logic [2:0] set_pos,
    output logic       blink,
    output logic       inc_pulse
);

    // state    | meaning
    // NORMAL   | time runs, no field selected
    // SET_HOUR | hour field selected for editing
    // SET_MIN  | minute field selected for editing
    // SET_SEC  | second field selected for editing

    if (DEBOUNCE_CYCLES < 2 || TIMEOUT_SEC < 1 || TIMEOUT_SEC > 63 || REPEAT_DELAY < 1) begin : g_param_check
        $error("watch_set_controller: parameter out of range");
    end

    localparam int              DB_W       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_RELOAD  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [5:0]      TMO_RELOAD = 6'(TIMEOUT_SEC);

    typedef enum logic [1:0] {
        S_NORMAL = 2'd0,
        S_HOUR   = 2'd1,
        S_MIN    = 2'd2,
        S_SEC    = 2'd3
    } state_t;

    state_t state, state_nxt;

    // bit 2 = mode, bit 1 = next, bit 0 = inc
    logic [2:0]      raw, sync1, sync2, acc, acc_d, press;
    logic [DB_W-1:0] db_cnt [3];
    logic [5:0]      tmo_left;
    logic            in_set, p_mode, p_next, p_inc, rep_evt, inc_evt, any_press, timeout_hit;

    assign raw = {btn_mode, btn_next, btn_inc};

    // Debounce: the down-counter only runs while the synchronized level differs from the accepted one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            acc   <= '0;
            acc_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            acc_d <= acc;
            press <= acc & ~acc_d;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == acc[i])
                    db_cnt[i] <= DB_RELOAD;
                else if (db_cnt[i] == '0)
                    acc[i] <= sync2[i];
                else
                    db_cnt[i] <= db_cnt[i] - 1'b1;
            end
        end
    end

    assign in_set      = (state != S_NORMAL);
    assign p_mode      = press[2];
    assign p_next      = press[1] & ~press[2];
    assign p_inc       = press[0] & ~press[1] & ~press[2];
    assign inc_evt     = in_set & (p_inc | (rep_evt & ~press[2] & ~press[1]));
    assign any_press   = (|press) | rep_evt;
    assign timeout_hit = in_set & (tmo_left == '0);

`ifdef WATCH_SET_AUTOREPEAT_EN
    localparam int                HOLD_W   = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);

    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            hold_cnt <= '0;
        else if (!acc[0] || !in_set || state_nxt == S_NORMAL)
            hold_cnt <= '0;
        else if (tick_2hz && hold_cnt != HOLD_MAX)
            hold_cnt <= hold_cnt + 1'b1;
    end

    assign rep_evt = in_set & acc[0] & tick_2hz & (hold_cnt == HOLD_MAX);
`else
    assign rep_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= S_NORMAL;
        else
            state <= state_nxt;
    end

    // A press in the terminal-count clk keeps the FSM in SET; any_press blocks the timeout exit.
    always_comb begin
        state_nxt = state;
        case (state)
            S_NORMAL: if (p_mode) state_nxt = S_HOUR;
            default: begin
                if (p_mode)
                    state_nxt = S_NORMAL;
                else if (p_next)
                    state_nxt = (state == S_HOUR) ? S_MIN : (state == S_MIN) ? S_SEC : S_HOUR;
                else if (!any_press && timeout_hit)
                    state_nxt = S_NORMAL;
            end
        endcase
    end

    always_comb begin
        mode    = 1'b0;
        set_pos = 3'b000;
        case (state)
            S_HOUR:  begin mode = 1'b1; set_pos = 3'b100; end
            S_MIN:   begin mode = 1'b1; set_pos = 3'b010; end
            S_SEC:   begin mode = 1'b1; set_pos = 3'b001; end
            default: begin mode = 1'b0; set_pos = 3'b000; end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo_left <= TMO_RELOAD;
        else if (!in_set || any_press)
            tmo_left <= TMO_RELOAD;
        else if (tick_1hz && tmo_left != '0)
            tmo_left <= tmo_left - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blink     <= 1'b0;
            inc_pulse <= 1'b0;
        end else begin
            inc_pulse <= inc_evt;
            if (state_nxt == S_NORMAL || p_mode || p_next || inc_evt)
                blink <= 1'b0;
            else if (tick_2hz)
                blink <= ~blink;
        end
    end

endmodule

// File: tb/tb_watch_set_controller.sv
// Self-checking bench for watch_set_controller: directed scenarios plus random press sequences
// checked against a field-index model of the setting mode.
module tb_watch_set_controller;

    localparam int DB   = 4;
    localparam int TMO  = 10;
    localparam int RD   = 3;
    localparam int HOLD = DB + 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       tick_2hz = 1'b0;
    logic [2:0] btns = 3'b000;
    logic       mode, blink, inc_pulse;
    logic [2:0] set_pos;

    int tests_run = 0;
    int tests_failed = 0;
    int inc_seen = 0;
    int bad_norm = 0;
    int bad_width = 0;
    logic inc_prev = 1'b0;
    int fld = 0;

    watch_set_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_SEC(TMO), .REPEAT_DELAY(RD)) dut (
        .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
        .btn_mode(btns[2]), .btn_next(btns[1]), .btn_inc(btns[0]),
        .mode(mode), .set_pos(set_pos), .blink(blink), .inc_pulse(inc_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (inc_pulse) begin
            inc_seen++;
            if (!mode) bad_norm++;
            if (inc_prev) bad_width++;
        end
        inc_prev = inc_pulse;
    end

    function automatic logic [2:0] onehot(input int f);
        case (f)
            1: return 3'b100;
            2: return 3'b010;
            3: return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_btn(input logic [2:0] b);
        btns = b;
        clks(HOLD);
        btns = 3'b000;
        clks(HOLD);
    endtask

    task automatic tick1();
        tick_1hz = 1'b1;
        clks(1);
        tick_1hz = 1'b0;
    endtask

    task automatic tick2();
        tick_2hz = 1'b1;
        clks(1);
        tick_2hz = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests_run++;
        if ({mode, set_pos, blink, inc_pulse} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b expected 000000", {mode, set_pos, blink, inc_pulse});
        end
        #10 reset = 1'b1;
        clks(20);
        tests_run++;
        if (inc_seen !== 0 || mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: inc_seen=%0d mode=%b expected 0 and 0", inc_seen, mode);
        end
    endtask

    task automatic test_glitch_latency();
        btns[2] = 1'b1;
        clks(2);
        btns[2] = 1'b0;
        clks(12);
        tests_run++;
        if (mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_reject: mode=%b expected 0", mode);
        end
        btns[2] = 1'b1;
        repeat (2 + DB + 1) @(posedge clk);
        #1;
        tests_run++;
        if (set_pos !== 3'b000) begin
            tests_failed++;
            $display("FAIL latency_early: set_pos=%b expected 000", set_pos);
        end
        clks(1);
        tests_run++;
        if (set_pos !== 3'b100 || mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_exact: set_pos=%b mode=%b expected 100 1", set_pos, mode);
        end
        clks(2);
        btns[2] = 1'b0;
        clks(HOLD);
        fld = 1;
    endtask

    task automatic test_next_cycle();
        logic [2:0] exp_seq [3];
        exp_seq[0] = 3'b010;
        exp_seq[1] = 3'b001;
        exp_seq[2] = 3'b100;
        for (int i = 0; i < 3; i++) begin
            press_btn(3'b010);
            tests_run++;
            if (set_pos !== exp_seq[i]) begin
                tests_failed++;
                $display("FAIL next_seq%0d: set_pos=%b expected %b", i, set_pos, exp_seq[i]);
            end
        end
        press_btn(3'b100);
        tests_run++;
        if (mode !== 1'b0 || set_pos !== 3'b000) begin
            tests_failed++;
            $display("FAIL mode_exit: mode=%b set_pos=%b expected 0 000", mode, set_pos);
        end
        fld = 0;
    endtask

    task automatic test_inc();
        int base;
        press_btn(3'b100);
        press_btn(3'b010);
        base = inc_seen;
        press_btn(3'b001);
        press_btn(3'b001);
        tests_run++;
        if (inc_seen - base !== 2 || set_pos !== 3'b010) begin
            tests_failed++;
            $display("FAIL inc_two: pulses=%0d set_pos=%b expected 2 010", inc_seen - base, set_pos);
        end
        press_btn(3'b100);
        base = inc_seen;
        press_btn(3'b001);
        tests_run++;
        if (inc_seen - base !== 0) begin
            tests_failed++;
            $display("FAIL inc_normal: pulses=%0d expected 0", inc_seen - base);
        end
        fld = 0;
    endtask

    task automatic test_timeout();
        press_btn(3'b100);
        press_btn(3'b010);
        press_btn(3'b010);
        for (int i = 0; i < TMO - 1; i++) begin tick1(); clks(2); end
        tick1();
        tests_run++;
        if (mode !== 1'b1 || set_pos !== 3'b001) begin
            tests_failed++;
            $display("FAIL timeout_pending: mode=%b set_pos=%b expected 1 001", mode, set_pos);
        end
        clks(1);
        tests_run++;
        if (mode !== 1'b0 || set_pos !== 3'b000) begin
            tests_failed++;
            $display("FAIL timeout_exit: mode=%b set_pos=%b expected 0 000", mode, set_pos);
        end
        press_btn(3'b100);
        press_btn(3'b010);
        press_btn(3'b010);
        for (int i = 0; i < TMO - 1; i++) begin tick1(); clks(2); end
        press_btn(3'b001);
        for (int i = 0; i < TMO - 1; i++) begin tick1(); clks(2); end
        tests_run++;
        if (mode !== 1'b1 || set_pos !== 3'b001) begin
            tests_failed++;
            $display("FAIL timeout_press_holds: mode=%b set_pos=%b expected 1 001", mode, set_pos);
        end
        tick1();
        clks(1);
        tests_run++;
        if (mode !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_after_press: mode=%b expected 0", mode);
        end
        fld = 0;
    endtask

    task automatic test_simultaneous();
        int base;
        press_btn(3'b110);
        tests_run++;
        if (set_pos !== 3'b100 || blink !== 1'b0) begin
            tests_failed++;
            $display("FAIL mode_next_same: set_pos=%b blink=%b expected 100 0", set_pos, blink);
        end
        base = inc_seen;
        press_btn(3'b011);
        tests_run++;
        if (set_pos !== 3'b010 || inc_seen - base !== 0) begin
            tests_failed++;
            $display("FAIL next_inc_same: set_pos=%b pulses=%0d expected 010 0", set_pos, inc_seen - base);
        end
        press_btn(3'b100);
        fld = 0;
    endtask

    task automatic test_random();
        int b, k, base, exp_inc;
        logic [2:0] code;
        for (int it = 0; it < 14; it++) begin
            b = $urandom_range(0, 2);
            code = 3'b001 << b;
            exp_inc = 0;
            if (b == 2) fld = (fld == 0) ? 1 : 0;
            else if (b == 1 && fld != 0) fld = (fld == 3) ? 1 : fld + 1;
            else if (b == 0 && fld != 0) exp_inc = 1;
            base = inc_seen;
            press_btn(code);
            tests_run++;
            if (set_pos !== onehot(fld) || mode !== (fld != 0) || blink !== 1'b0 || inc_seen - base !== exp_inc) begin
                tests_failed++;
                $display("FAIL random_press%0d: set_pos=%b mode=%b blink=%b pulses=%0d expected %b %b 0 %0d",
                         it, set_pos, mode, blink, inc_seen - base, onehot(fld), fld != 0, exp_inc);
            end
            k = $urandom_range(1, 7);
            for (int j = 0; j < k; j++) begin tick2(); clks(2); end
            tests_run++;
            if (blink !== ((fld != 0) ? k[0] : 1'b0)) begin
                tests_failed++;
                $display("FAIL random_blink%0d: blink=%b after %0d ticks field=%0d", it, blink, k, fld);
            end
        end
    endtask

    task automatic test_autorepeat();
        int base, exp_inc;
        if (fld == 0) begin
            press_btn(3'b100);
            fld = 1;
        end
        base = inc_seen;
        btns[0] = 1'b1;
        clks(HOLD);
        for (int i = 0; i < 6; i++) begin tick2(); clks(3); end
        btns[0] = 1'b0;
        clks(HOLD);
`ifdef WATCH_SET_AUTOREPEAT_EN
        exp_inc = 1 + (6 - RD);
`else
        exp_inc = 1;
`endif
        tests_run++;
        if (inc_seen - base !== exp_inc || mode !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_inc: pulses=%0d mode=%b expected %0d 1", inc_seen - base, mode, exp_inc);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        btns[2] = 1'b1;
        clks(3);
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if ({mode, set_pos, blink, inc_pulse} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got %b expected 000000", {mode, set_pos, blink, inc_pulse});
        end
        btns = 3'b000;
        clks(2);
        reset = 1'b1;
        base = inc_seen;
        clks(25);
        tests_run++;
        if (mode !== 1'b0 || set_pos !== 3'b000 || inc_seen - base !== 0) begin
            tests_failed++;
            $display("FAIL reset_residual: mode=%b set_pos=%b pulses=%0d expected 0 000 0",
                     mode, set_pos, inc_seen - base);
        end
        fld = 0;
    endtask

    task automatic test_invariants();
        tests_run++;
        if (bad_norm !== 0 || bad_width !== 0) begin
            tests_failed++;
            $display("FAIL inc_invariant: in_normal=%0d wide=%0d expected 0 0", bad_norm, bad_width);
        end
    endtask

    initial begin
        test_reset();
        test_glitch_latency();
        test_next_cycle();
        test_inc();
        test_timeout();
        test_simultaneous();
        test_random();
        test_autorepeat();
        test_reset_mid();
        test_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
